// File: rtl/ram8_16_clr.sv
// ============================================================================
// Module   : ram8_16_clr
// Brief    : 8 x 16-bit register bank with a one-hot write decode, an
//            addressed combinational read and a sequential sweep-clear engine.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram8_16_clr #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       address,
    input  logic             load,
    input  logic             clr_req,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] out
);

    localparam int             c_AW   = 3;
    localparam logic [c_AW-1:0] c_LAST = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [c_AW-1:0]            r_ptr;
    logic [c_AW-1:0]            w_ptr_nxt;
    logic [DEPTH-1:0]           w_wr_sel;
    logic [DEPTH-1:0]           w_clr_sel;
    logic [DEPTH-1:0][WIDTH-1:0] w_words;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Requests arriving during a sweep are dropped, never queued.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == c_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign ready = (r_state == ST_IDLE);
    assign busy  = (r_state == ST_CLEAR);

    // Writes and sweep-clears are mutually exclusive by state, so each word
    // sees at most one select per edge.
    always_comb begin
        w_wr_sel  = '0;
        w_clr_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wr_sel[i]  = load && ready && (address == c_AW'(i));
            w_clr_sel[i] = busy && (r_ptr == c_AW'(i));
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WIDTH-1:0] r_word;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_word <= '0;
                end else if (w_clr_sel[gi]) begin
                    r_word <= '0;
                end else if (w_wr_sel[gi]) begin
                    r_word <= in;
                end
            end

            assign w_words[gi] = r_word;
        end
    endgenerate

    assign out = w_words[address];

endmodule

`default_nettype wire

// File: doc/ram8_16_clr.md
Name: ram8_16_clr

Overview:
- 8-word x 16-bit register bank; the storage stage directly downstream of the 8-way 16-bit demux.
- The write-load is decoded one-hot across the 8 words (demux); read data is selected by address (mux).
- Adds a sequential sweep-clear engine with a busy/ready handshake, so the CPU side can zero the bank without 8 explicit writes.
- Used as the building block for larger RAM stages (RAM64 etc.).

Parameters:
- WIDTH, 16, data width of each word (the bench exercises 16 only).
- DEPTH, 8, number of words; fixed at 8 (3-bit address). Other values are unsupported.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  write data.
- address  input  3  word select for both write and read.
- load  input  1  write request for word[address].
- clr_req  input  1  request to zero all 8 words.
- ready  output  1  high when a write on load will be accepted.
- busy  output  1  high while the clear sweep is in progress.
- out  output  WIDTH  contents of word[address], combinational read.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset (rst_n=0, asynchronous, no clock needed):
  - all 8 words = 0; FSM = IDLE; sweep pointer = 0.
  - busy = 0; ready = 1; out = 0.
- Deassertion of rst_n takes effect at the next rising edge.
- Read path:
  - out = word[address], purely combinational, zero cycles from an address change.
  - A write on edge N is visible on out after edge N when address points at that word.
- Write path:
  - Write enable is decoded one-hot from address, so exactly one word is written per accepted write.
  - On a rising edge with load=1 and ready=1: word[address] <= in. All other words hold.
  - load=1 with ready=0 is dropped: not queued, not retried, no word changes.
- FSM states: IDLE, CLEAR.
- IDLE:
  - busy=0, ready=1.
  - clr_req=1 at an edge -> CLEAR, pointer <= 0.
- CLEAR:
  - busy=1, ready=0.
  - Each edge: word[pointer] <= 0, pointer <= pointer+1.
  - When pointer==7 at an edge, word[7] is cleared, the FSM -> IDLE and pointer <= 0.
  - The sweep always lasts exactly 8 cycles; busy is high for 8 cycles starting the cycle after clr_req is sampled.
- Simultaneous load and clr_req in IDLE:
  - The write is accepted (ready was 1) and the sweep starts.
  - The written word is zeroed later in the sweep; net result is all words 0.
- clr_req during CLEAR is ignored: no restart, no extension, no queueing.
- clr_req held high continuously: a new sweep starts on the first IDLE edge after the previous sweep completes (back-to-back sweeps separated by one IDLE cycle).
- out during CLEAR reflects the current, partially cleared contents. Words not yet swept keep their old values.
- rst_n asserted mid-sweep: immediate return to the reset state. The sweep is not resumed after reset releases.
- Pointer arithmetic is 3-bit and wraps 7->0. There is no out-of-range address: all 8 codes are valid.
- No X propagation allowed: every word, the pointer and the FSM are reset.

Test Plan:
- Reset then sweep reads: assert rst_n=0, release, read addresses 0..7 -> out=0x0000 each; ready=1, busy=0.
- Write/readback: write word k = 0x1000+k for k=0..7 (load=1, one per cycle), then read 0..7 -> out=0x1000..0x1007. A write to address 3 leaves the other 7 words unchanged.
- Clear sweep: after filling with 0xFFFF, pulse clr_req for one cycle.
  - busy=1 and ready=0 for exactly 8 cycles.
  - Mid-sweep at cycle 4, word[0..3]=0 and word[4..7]=0xFFFF.
  - After the sweep, all words read 0 and busy=0.
- Blocked write: during CLEAR, drive load=1, address=7, in=0xBEEF -> the write is dropped; word[7]=0 after the sweep. A second clr_req pulse mid-sweep does not extend busy beyond 8 cycles.
- Simultaneous events: in IDLE, same edge load=1 (address=2, in=0xABCD) and clr_req=1 -> out at address 2 reads 0xABCD for cycle 1, then 0 from the third sweep edge onward; all words are 0 at the end.
- Async reset mid-sweep: assert rst_n=0 at sweep cycle 3, between edges -> busy=0, ready=1 and all words 0 immediately. After release, no sweep resumes and a write to address 5 of 0x0055 reads back 0x0055.
